// File: rtl/i2c_xfer_seq_if.sv
// ---------------------------------------------------------------------------
// i2c_xfer_seq_if
// Bundles the request/response port of the transaction sequencer together
// with its command/status port toward the byte-level I2C master.
//
// Modports:
//   slave  - the sequencer (i2c_xfer_seq): consumes requests, produces
//            responses, drives master commands, observes master status.
//   master - the surrounding system: issues requests, takes responses, and
//            plays the byte-level I2C master (status/read data).
//
// Request handshake: a request transfers on a rising clk edge where both
// req_valid and req_ready are high; req_* fields must be stable while
// req_valid is high. rsp_valid is a one-cycle pulse with no back-pressure.
//
// Signals:
//   req_valid/req_ready/req_rd/req_dev/req_reg/req_wdat : request
//   rsp_valid/rsp_err/rsp_rdat                          : response
//   m_cmd/m_dat/m_ds                                    : master command
//   m_status/m_rdat                                     : master status
//   dbg_state                                           : sequencer FSM state
// ---------------------------------------------------------------------------
interface i2c_xfer_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdat;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdat;
    logic [4:0] m_cmd;
    logic [7:0] m_dat;
    logic       m_ds;
    logic [3:0] m_status;
    logic [7:0] m_rdat;
    logic [3:0] dbg_state;

    modport slave (
        input  req_valid, req_rd, req_dev, req_reg, req_wdat, m_status, m_rdat,
        output req_ready, rsp_valid, rsp_err, rsp_rdat, m_cmd, m_dat, m_ds,
               dbg_state
    );

    modport master (
        output req_valid, req_rd, req_dev, req_reg, req_wdat, m_status, m_rdat,
        input  req_ready, rsp_valid, rsp_err, rsp_rdat, m_cmd, m_dat, m_ds,
               dbg_state
    );
endinterface

// File: rtl/i2c_xfer_seq.sv
// ---------------------------------------------------------------------------
// i2c_xfer_seq
// Register-level transaction sequencer for a byte-level I2C master. Takes one
// read/write-register request, walks the START/WRTE/READ/STOP command list
// one strobe at a time, checks ACK per byte, clears master errors, retries
// arbitration loss after a back-off, and returns a single response.
//
// Ports:
//   clk     - clock
//   rst     - asynchronous, active-high reset (aborts any sequence, no STOP)
//   io_bus  - i2c_xfer_seq_if.slave (request, response, master cmd/status,
//             dbg_state = current FSM state)
//
// Parameters:
//   RETRIES - arbitration-lost retries per request (0..15)
//   BACKOFF - idle cycles between an arbitration loss and the retry (>=1)
//   TMO     - cycles allowed for master BSY to fall (>=4)
// ---------------------------------------------------------------------------
module i2c_xfer_seq #(
    parameter int RETRIES = 3,
    parameter int BACKOFF = 16,
    parameter int TMO     = 65535
) (
    input  logic           clk,
    input  logic           rst,
    i2c_xfer_seq_if.slave  io_bus
);

    localparam logic [3:0] ST_RST   = 4'd0;  // first cycle after reset
    localparam logic [3:0] ST_IDLE  = 4'd1;
    localparam logic [3:0] ST_ISSUE = 4'd2;  // strobe a step command
    localparam logic [3:0] ST_GUARD = 4'd3;
    localparam logic [3:0] ST_WAIT  = 4'd4;
    localparam logic [3:0] ST_EVAL  = 4'd5;
    localparam logic [3:0] ST_CLR   = 4'd6;  // strobe a status clear
    localparam logic [3:0] ST_BOFF  = 4'd7;
    localparam logic [3:0] ST_STOPI = 4'd8;  // strobe a lone STOP after NACK
    localparam logic [3:0] ST_RESP  = 4'd9;

    // Which kind of command is in flight, so EVAL knows how to react.
    localparam logic [1:0] K_STEP = 2'd0;
    localparam logic [1:0] K_CLR  = 2'd1;
    localparam logic [1:0] K_STOP = 2'd2;

    localparam int MAXC = (TMO > BACKOFF) ? TMO : BACKOFF;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
    localparam logic [CW-1:0] BOFF_LAST = CW'(BACKOFF - 1);

    logic [3:0]    r_state;
    logic [1:0]    r_kind;
    logic [1:0]    r_step;
    logic [3:0]    r_retry;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic [6:0]    r_dev;
    logic [7:0]    r_reg;
    logic [7:0]    r_wdat;
    logic [4:0]    r_cmd;
    logic [7:0]    r_dat;
    logic [2:0]    r_stat;       // {ACK, ALO, ERR} when BSY first seen low
    logic          r_alo_lat;    // ALO of the error that triggered the clear
    logic          r_after_stop; // clear follows the NACK STOP: keep err=1
    logic [1:0]    r_rsp_err;
    logic [7:0]    r_rsp_rdat;

    logic          w_last;
    logic [1:0]    w_step_nx;
    logic [12:0]   w_next_word;

    // {cmd, dat} for one entry of the write/read step lists.
    function automatic logic [12:0] step_word(input logic rd, input logic [1:0] step,
                                              input logic [6:0] dev, input logic [7:0] rg,
                                              input logic [7:0] wd);
        case (step)
            2'd0:    return {5'h09, dev, 1'b0};
            2'd1:    return {5'h08, rg};
            2'd2:    return rd ? {5'h09, dev, 1'b1} : {5'h0a, wd};
            default: return {5'h16, 8'h00};
        endcase
    endfunction

    assign w_last      = r_rd ? (r_step == 2'd3) : (r_step == 2'd2);
    assign w_step_nx   = 2'(r_step + 2'd1);
    assign w_next_word = step_word(r_rd, w_step_nx, r_dev, r_reg, r_wdat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RST;
            r_kind       <= K_STEP;
            r_step       <= 2'd0;
            r_retry      <= 4'd0;
            r_cnt        <= '0;
            r_rd         <= 1'b0;
            r_dev        <= 7'd0;
            r_reg        <= 8'd0;
            r_wdat       <= 8'd0;
            r_cmd        <= 5'd0;
            r_dat        <= 8'd0;
            r_stat       <= 3'd0;
            r_alo_lat    <= 1'b0;
            r_after_stop <= 1'b0;
            r_rsp_err    <= 2'd0;
            r_rsp_rdat   <= 8'd0;
        end else begin
            case (r_state)
                ST_RST: r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (io_bus.req_valid) begin
                        r_rd           <= io_bus.req_rd;
                        r_dev          <= io_bus.req_dev;
                        r_reg          <= io_bus.req_reg;
                        r_wdat         <= io_bus.req_wdat;
                        r_step         <= 2'd0;
                        r_retry        <= 4'(RETRIES);
                        r_kind         <= K_STEP;
                        {r_cmd, r_dat} <= step_word(io_bus.req_rd, 2'd0, io_bus.req_dev,
                                                    io_bus.req_reg, io_bus.req_wdat);
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_CLR, ST_STOPI: r_state <= ST_GUARD;
                ST_GUARD: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!io_bus.m_status[0]) begin
                        r_stat  <= io_bus.m_status[3:1];
                        r_state <= ST_EVAL;
                    end else if (r_cnt == TMO_LAST) begin
                        // Master is stuck: respond without issuing anything more.
                        r_rsp_err  <= 2'd3;
                        r_rsp_rdat <= 8'h00;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EVAL: begin
                    case (r_kind)
                        K_STEP: begin
                            if (r_stat[0]) begin
                                r_alo_lat    <= r_stat[1];
                                r_after_stop <= 1'b0;
                                r_kind       <= K_CLR;
                                r_cmd        <= 5'd0;
                                r_state      <= ST_CLR;
                            end else if (r_cmd[3] && !r_stat[2]) begin
                                if (r_cmd[1]) begin
                                    r_rsp_err  <= 2'd1;
                                    r_rsp_rdat <= 8'h00;
                                    r_state    <= ST_RESP;
                                end else begin
                                    // Release the bus before reporting the NACK.
                                    r_kind  <= K_STOP;
                                    r_cmd   <= 5'h02;
                                    r_state <= ST_STOPI;
                                end
                            end else if (w_last) begin
                                r_rsp_err  <= 2'd0;
                                r_rsp_rdat <= r_rd ? io_bus.m_rdat : 8'h00;
                                r_state    <= ST_RESP;
                            end else begin
                                r_step         <= w_step_nx;
                                {r_cmd, r_dat} <= w_next_word;
                                r_state        <= ST_ISSUE;
                            end
                        end
                        K_STOP: begin
                            if (r_stat[0]) begin
                                r_after_stop <= 1'b1;
                                r_kind       <= K_CLR;
                                r_cmd        <= 5'd0;
                                r_state      <= ST_CLR;
                            end else begin
                                r_rsp_err  <= 2'd1;
                                r_rsp_rdat <= 8'h00;
                                r_state    <= ST_RESP;
                            end
                        end
                        default: begin
                            // Status of the clear itself is not inspected.
                            r_rsp_rdat <= 8'h00;
                            if (r_after_stop) begin
                                r_rsp_err <= 2'd1;
                                r_state   <= ST_RESP;
                            end else if (r_alo_lat && r_retry != 4'd0) begin
                                r_retry <= r_retry - 4'd1;
                                r_cnt   <= '0;
                                r_state <= ST_BOFF;
                            end else begin
                                r_rsp_err <= r_alo_lat ? 2'd2 : 2'd3;
                                r_state   <= ST_RESP;
                            end
                        end
                    endcase
                end
                ST_BOFF: begin
                    if (r_cnt == BOFF_LAST) begin
                        r_step         <= 2'd0;
                        r_kind         <= K_STEP;
                        {r_cmd, r_dat} <= step_word(r_rd, 2'd0, r_dev, r_reg, r_wdat);
                        r_state        <= ST_ISSUE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.req_ready = (r_state == ST_IDLE);
    assign io_bus.rsp_valid = (r_state == ST_RESP);
    assign io_bus.rsp_err   = r_rsp_err;
    assign io_bus.rsp_rdat  = r_rsp_rdat;
    assign io_bus.m_cmd     = r_cmd;
    assign io_bus.m_dat     = r_dat;
    assign io_bus.m_ds      = (r_state == ST_ISSUE) || (r_state == ST_CLR) ||
                              (r_state == ST_STOPI);
    assign io_bus.dbg_state = r_state;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_xfer_seq
// Self-checking bench for i2c_xfer_seq. A reference model turns each request
// plus a fault scenario into the list of master commands the sequencer must
// strobe and the response it must return; a master responder plays back the
// scenario's status for every strobe; a monitor compares strobes in order.
// ---------------------------------------------------------------------------
module tb_i2c_xfer_seq;

    localparam int RETRIES = 3;
    localparam int BACKOFF = 16;
    localparam int TMO     = 40;

    localparam logic [4:0] C_STRT = 5'h01;
    localparam logic [4:0] C_STOP = 5'h02;
    localparam logic [4:0] C_READ = 5'h04;
    localparam logic [4:0] C_WRTE = 5'h08;
    localparam logic [4:0] C_NACK = 5'h10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_xfer_seq_if bus();

    i2c_xfer_seq #(.RETRIES(RETRIES), .BACKOFF(BACKOFF), .TMO(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // exp_q entry: {restart_after_backoff, dat_care, cmd[4:0], dat[7:0]}
    logic [14:0] exp_q[$];
    // out_q entry: {hang, err, alo, ack, latency[3:0]} returned for each strobe
    logic [7:0]  out_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Fault scenario for the next request; -1 means "never".
    int sc_nack, sc_alo_step, sc_alo_n, sc_err_step, sc_hang;
    logic sc_stop_err;

    task automatic set_sc(input int nack, input int alo_step, input int alo_n,
                          input int err_step, input int hang, input logic stop_err);
        sc_nack = nack; sc_alo_step = alo_step; sc_alo_n = alo_n;
        sc_err_step = err_step; sc_hang = hang; sc_stop_err = stop_err;
    endtask

    task automatic push_cmd(input logic restart, input logic care, input logic [4:0] c,
                            input logic [7:0] d, input logic hang, input logic err,
                            input logic alo, input logic ack);
        exp_q.push_back({restart, care, c, d});
        out_q.push_back({hang, err, alo, ack, 4'($urandom_range(1, 6))});
    endtask

    // Reference model: walks the register transaction as a list of bus
    // steps, applying the scenario to each one.
    task automatic build_expect(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input logic [7:0] rdat,
                                output logic [1:0] e, output logic [7:0] er);
        logic [4:0] c[4];
        logic [7:0] d[4];
        int  retries, attempt, n;
        bit  done, hang, alo, err, ack;
        retries = RETRIES; attempt = 0; done = 0; n = rd ? 4 : 3; e = 2'd0;
        c[0] = C_STRT | C_WRTE; d[0] = {dev, 1'b0};
        c[1] = C_WRTE;          d[1] = rg;
        if (rd) begin
            c[2] = C_STRT | C_WRTE;          d[2] = {dev, 1'b1};
            c[3] = C_READ | C_NACK | C_STOP; d[3] = 8'h00;
        end else begin
            c[2] = C_WRTE | C_STOP; d[2] = wd;
            c[3] = 5'h00;           d[3] = 8'h00;
        end
        while (!done) begin
            for (int i = 0; i < n && !done; i++) begin
                hang = (i == sc_hang);
                alo  = (i == sc_alo_step) && (attempt < sc_alo_n);
                err  = alo || (i == sc_err_step);
                ack  = (i != sc_nack);
                push_cmd(i == 0 && attempt > 0, !(rd && i == 3), c[i], d[i], hang, err, alo, ack);
                if (hang) begin
                    e = 2'd3; done = 1;
                end else if (err) begin
                    push_cmd(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
                    if (alo && retries > 0) begin
                        retries--; attempt++;
                        break;
                    end
                    e = alo ? 2'd2 : 2'd3; done = 1;
                end else if ((c[i] & C_WRTE) != 0 && !ack) begin
                    e = 2'd1; done = 1;
                    if ((c[i] & C_STOP) == 0) begin
                        push_cmd(1'b0, 1'b0, C_STOP, 8'h00, 1'b0, sc_stop_err, 1'b0, 1'b1);
                        if (sc_stop_err)
                            push_cmd(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
                    end
                end else if (i == n - 1) begin
                    e = 2'd0; done = 1;
                end
            end
        end
        er = (rd && e == 2'd0) ? rdat : 8'h00;
    endtask

    // ---------------- master responder ----------------
    logic [7:0] rsp_o;
    logic [3:0] pend_stat;
    int         busy_cnt = 0;
    logic       hang_active = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            hang_active   = 1'b0;
            busy_cnt      = 0;
            bus.m_status  = 4'b1000;
        end else if (bus.m_ds) begin
            rsp_o         = (out_q.size() != 0) ? out_q.pop_front() : 8'h11;
            bus.m_status  = 4'b0001;
            hang_active   = rsp_o[7];
            busy_cnt      = int'(rsp_o[3:0]);
            pend_stat     = {rsp_o[4], rsp_o[5], rsp_o[6], 1'b0};
        end else if (hang_active) begin
            if (bus.rsp_valid) begin
                hang_active  = 1'b0;
                bus.m_status = 4'b1000;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.m_status = pend_stat;
        end
    end

    // ---------------- strobe monitor ----------------
    logic [14:0] mon_e;
    int          strobe_cyc = 0;

    always @(negedge clk) begin
        if (!rst && bus.m_ds) begin
            mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h1fff;
            check_eq("strobe_cmd", 32'(bus.m_cmd), 32'(mon_e[12:8]));
            if (mon_e[13]) check_eq("strobe_dat", 32'(bus.m_dat), 32'(mon_e[7:0]));
            if (mon_e[14]) check_eq("backoff_gap_ok", 32'((cyc - strobe_cyc) > BACKOFF), 32'd1);
            strobe_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, input logic [7:0] rdat);
        bit got = 0;
        bus.m_rdat    = rdat;
        bus.req_rd    = rd;
        bus.req_dev   = dev;
        bus.req_reg   = rg;
        bus.req_wdat  = wd;
        bus.req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (bus.req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check_eq("req_accepted", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_rd    = 1'($urandom_range(0, 1));
        bus.req_dev   = 7'($urandom);
        bus.req_reg   = 8'($urandom);
        bus.req_wdat  = 8'($urandom);
    endtask

    task automatic run_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rdat);
        logic [1:0] e;
        logic [7:0] er;
        bit got = 0;
        build_expect(rd, dev, rg, wd, rdat, e, er);
        send_req(rd, dev, rg, wd, rdat);
        for (int k = 0; k < TMO * 8 + 2000; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin got = 1; break; end
        end
        check_eq("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(e));
            check_eq("rsp_rdat", 32'(bus.rsp_rdat), 32'(er));
            if (sc_hang >= 0)
                check_eq("tmo_latency_ok",
                         32'((cyc - strobe_cyc) >= TMO && (cyc - strobe_cyc) <= TMO + 4), 32'd1);
            @(negedge clk);
            check_eq("rsp_pulse_one_cycle", 32'(bus.rsp_valid), 32'd0);
            check_eq("rsp_err_hold", 32'(bus.rsp_err), 32'(e));
        end
        check_eq("strobes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        out_q.delete();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        check_eq({tag, "_rsp_rdat"},  32'(bus.rsp_rdat),  32'd0);
        check_eq({tag, "_m_cmd"},     32'(bus.m_cmd),     32'd0);
        check_eq({tag, "_m_dat"},     32'(bus.m_dat),     32'd0);
        check_eq({tag, "_m_ds"},      32'(bus.m_ds),      32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("ready_first_cycle", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check_eq("ready_idle", 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    int   n, mode;
    logic rd;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rd    = 1'b0;
        bus.req_dev   = 7'd0;
        bus.req_reg   = 8'd0;
        bus.req_wdat  = 8'd0;
        bus.m_rdat    = 8'd0;
        set_sc(-1, -1, 0, -1, -1, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        // Directed cases
        run_req(1'b0, 7'h3b, 8'h10, 8'ha5, 8'h00);              // clean write
        run_req(1'b1, 7'h3b, 8'h02, 8'h00, 8'hcc);              // clean read
        set_sc(0, -1, 0, -1, -1, 1'b0);
        run_req(1'b0, 7'h11, 8'h20, 8'h5a, 8'h00);              // absent device
        set_sc(-1, 1, 2, -1, -1, 1'b0);
        run_req(1'b0, 7'h3b, 8'h10, 8'ha5, 8'h00);              // ALO twice, then ok
        set_sc(-1, 0, 99, -1, -1, 1'b0);
        run_req(1'b1, 7'h22, 8'h44, 8'h00, 8'h9e);              // ALO every attempt
        set_sc(-1, -1, 0, 2, -1, 1'b0);
        run_req(1'b1, 7'h22, 8'h44, 8'h00, 8'h9e);              // plain master error
        set_sc(1, -1, 0, -1, -1, 1'b1);
        run_req(1'b0, 7'h05, 8'h06, 8'h07, 8'h00);              // NACK, error on STOP
        set_sc(-1, -1, 0, -1, 0, 1'b0);
        run_req(1'b0, 7'h3b, 8'h10, 8'ha5, 8'h00);              // BSY stuck -> timeout

        // Reset in the middle of WAIT
        set_sc(-1, -1, 0, -1, 0, 1'b0);
        begin
            logic [1:0] e;
            logic [7:0] er;
            build_expect(1'b0, 7'h6d, 8'h33, 8'h44, 8'h00, e, er);
            send_req(1'b0, 7'h6d, 8'h33, 8'h44, 8'h00);
        end
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_wait_reset");
        exp_q.delete();
        out_q.delete();
        repeat (2) @(negedge clk);
        release_reset();
        set_sc(-1, -1, 0, -1, -1, 1'b0);
        run_req(1'b1, 7'h6d, 8'h33, 8'h00, 8'h81);              // accepted after reset

        // Randomized requests
        for (int it = 0; it < 40; it++) begin
            rd   = 1'($urandom_range(0, 1));
            n    = rd ? 4 : 3;
            mode = $urandom_range(0, 6);
            set_sc(-1, -1, 0, -1, -1, 1'b0);
            case (mode)
                1: sc_nack = $urandom_range(0, n - 1);
                2: begin
                    sc_alo_step = $urandom_range(0, n - 1);
                    sc_alo_n    = $urandom_range(0, RETRIES + 1);
                end
                3: sc_err_step = $urandom_range(0, n - 1);
                4: begin
                    sc_nack     = $urandom_range(0, 1);
                    sc_stop_err = 1'($urandom_range(0, 1));
                end
                5: sc_hang = $urandom_range(0, n - 1);
                default: ;
            endcase
            run_req(rd, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
